// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin front end that lets two client blocks share the
// single-port 64x4 mem array. The winner's command is latched, held on the
// mem pins for ACC_CYC cycles, and completion is reported with a one-cycle
// done pulse plus a registered read-data word per requester.
//
// Optional feature macro: MEM_ARB_LOCK_EN
//   When defined, r0_lock/r1_lock inputs let the current owner keep the
//   memory across back-to-back requests; otherwise pure round-robin.
//
// state  | meaning
// IDLE   | memory idle, arbitrating between r0_req and r1_req
// ACCESS | mem_e high, latched command on the pins, counting the window
// DONE   | winner's done pulse, read data already registered
module mem_arbiter #(
    parameter int AW      = 6,
    parameter int DW      = 4,
    parameter int ACC_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef MEM_ARB_LOCK_EN
    input  logic          r0_lock,
    input  logic          r1_lock,
`endif
    input  logic          r0_req,
    input  logic          r0_rw,
    input  logic [AW-1:0] r0_a,
    input  logic [DW-1:0] r0_di,
    output logic          r0_gnt,
    output logic          r0_done,
    output logic [DW-1:0] r0_rd,
    input  logic          r1_req,
    input  logic          r1_rw,
    input  logic [AW-1:0] r1_a,
    input  logic [DW-1:0] r1_di,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic [DW-1:0] r1_rd,
    output logic          mem_e,
    output logic          mem_rw,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_d
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

    state_t        state_q, state_d;
    logic          last_q;
    logic          win_q;
    logic          cmd_rw_q;
    logic [AW-1:0] cmd_a_q;
    logic [DW-1:0] cmd_di_q;
    logic [3:0]    cnt_q;
    logic [DW-1:0] rd0_q, rd1_q;
    logic          take;
    logic          pick;

`ifdef MEM_ARB_LOCK_EN
    logic lock_q;
    logic win_lock;
    assign win_lock = win_q ? r1_lock : r0_lock;
`endif

    // Arbitration: a tie goes to the requester that did not win last time,
    // or to the locked owner while a lock is held.
    always_comb begin
        take = 1'b0;
        pick = 1'b0;
        if (r0_req && r1_req) begin
            take = 1'b1;
            pick = ~last_q;
`ifdef MEM_ARB_LOCK_EN
            if (lock_q) pick = win_q;
`endif
        end else if (r0_req) begin
            take = 1'b1;
            pick = 1'b0;
        end else if (r1_req) begin
            take = 1'b1;
            pick = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, window counter, read capture and priority bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            cmd_rw_q <= 1'b1;
            cmd_a_q  <= '0;
            cmd_di_q <= '0;
            cnt_q    <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        win_q    <= pick;
                        cmd_rw_q <= pick ? r1_rw : r0_rw;
                        cmd_a_q  <= pick ? r1_a  : r0_a;
                        cmd_di_q <= pick ? r1_di : r0_di;
                        cnt_q    <= CNT_LOAD;
`ifdef MEM_ARB_LOCK_EN
                        if (lock_q && (pick != win_q)) lock_q <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (cmd_rw_q) begin
                            if (win_q) rd1_q <= mem_d;
                            else       rd0_q <= mem_d;
                        end
`ifdef MEM_ARB_LOCK_EN
                        if (win_lock) begin
                            lock_q <= 1'b1;
                        end else begin
                            lock_q <= 1'b0;
                            last_q <= win_q;
                        end
`else
                        last_q <= win_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state; mem_rw parks at read outside ACCESS.
    always_comb begin
        mem_e   = (state_q == ACCESS);
        mem_rw  = (state_q == ACCESS) ? cmd_rw_q : 1'b1;
        r0_gnt  = (state_q != IDLE) && !win_q;
        r1_gnt  = (state_q != IDLE) &&  win_q;
        r0_done = (state_q == DONE) && !win_q;
        r1_done = (state_q == DONE) &&  win_q;
    end

    assign mem_a  = cmd_a_q;
    assign mem_di = cmd_di_q;
    assign r0_rd  = rd0_q;
    assign r1_rd  = rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (ACC_CYC=1 and ACC_CYC=3) share the
// stimulus, selected by sel; each has its own mem model and reference model.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       r0_req = 1'b0, r0_rw = 1'b0;
    logic [5:0] r0_a = '0;
    logic [3:0] r0_di = '0;
    logic       r1_req = 1'b0, r1_rw = 1'b0;
    logic [5:0] r1_a = '0;
    logic [3:0] r1_di = '0;
`ifdef MEM_ARB_LOCK_EN
    logic       r0_lock = 1'b0, r1_lock = 1'b0;
`endif

    logic [1:0] act;
    logic [1:0] g0, g1, d0, d1, e, rw;
    logic [5:0] ma  [2];
    logic [3:0] mdi [2];
    logic [3:0] md  [2];
    logic [3:0] rd0 [2];
    logic [3:0] rd1 [2];

    assign act = {sel, ~sel};

    for (genvar i = 0; i < 2; i++) begin : g_inst
        logic [3:0] marr [64];

        mem_arbiter #(.AW(6), .DW(4), .ACC_CYC(i == 0 ? 1 : 3)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
`ifdef MEM_ARB_LOCK_EN
            .r0_lock(r0_lock),
            .r1_lock(r1_lock),
`endif
            .r0_req(r0_req & act[i]),
            .r0_rw(r0_rw),
            .r0_a(r0_a),
            .r0_di(r0_di),
            .r0_gnt(g0[i]),
            .r0_done(d0[i]),
            .r0_rd(rd0[i]),
            .r1_req(r1_req & act[i]),
            .r1_rw(r1_rw),
            .r1_a(r1_a),
            .r1_di(r1_di),
            .r1_gnt(g1[i]),
            .r1_done(d1[i]),
            .r1_rd(rd1[i]),
            .mem_e(e[i]),
            .mem_rw(rw[i]),
            .mem_a(ma[i]),
            .mem_di(mdi[i]),
            .mem_d(md[i])
        );

        // mem model: cleared while reset is held, synchronous write, async read
        always @(posedge clk) begin
            if (!rst_n) begin
                for (int j = 0; j < 64; j++) marr[j] <= 4'h0;
            end else if (e[i] && !rw[i]) begin
                marr[ma[i]] <= mdi[i];
            end
        end
        assign md[i] = marr[ma[i]];
    end

    logic       o_e, o_rw, o_g0, o_g1, o_d0, o_d1;
    logic [5:0] o_a;
    logic [3:0] o_di, o_rd0, o_rd1;
    assign o_e   = e[sel];
    assign o_rw  = rw[sel];
    assign o_g0  = g0[sel];
    assign o_g1  = g1[sel];
    assign o_d0  = d0[sel];
    assign o_d1  = d1[sel];
    assign o_a   = ma[sel];
    assign o_di  = mdi[sel];
    assign o_rd0 = rd0[sel];
    assign o_rd1 = rd1[sel];

    int total = 0;
    int bad   = 0;

    // reference model: memory contents, read registers, last winner
    logic [3:0] ref_mem [2][64];
    logic [3:0] ref_rd  [2][2];
    bit         last_ref [2];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 64; j++) ref_mem[s][j] = 4'h0;
            ref_rd[s][0] = 4'h0;
            ref_rd[s][1] = 4'h0;
            last_ref[s]  = 1'b1;
        end
    endtask

    task automatic apply(input int s, input bit who, input bit c_rw,
                         input logic [5:0] c_a, input logic [3:0] c_di);
        if (c_rw) ref_rd[s][who] = ref_mem[s][c_a];
        else      ref_mem[s][c_a] = c_di;
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 2; i++) begin
            chk("rst_mem_e",  e[i],   1'b0);
            chk("rst_mem_rw", rw[i],  1'b1);
            chk("rst_mem_a",  ma[i],  6'h00);
            chk("rst_mem_di", mdi[i], 4'h0);
            chk("rst_gnt",    {g1[i], g0[i]}, 2'b00);
            chk("rst_done",   {d1[i], d0[i]}, 2'b00);
            chk("rst_rd0",    rd0[i], 4'h0);
            chk("rst_rd1",    rd1[i], 4'h0);
        end
    endtask

    task automatic set_req(input bit who, input bit v);
        if (who) r1_req = v;
        else     r0_req = v;
    endtask

    task automatic scramble(input bit who);
        if (who) begin
            r1_rw = 1'($urandom); r1_a = 6'($urandom); r1_di = 4'($urandom);
        end else begin
            r0_rw = 1'($urandom); r0_a = 6'($urandom); r0_di = 4'($urandom);
        end
    endtask

    // One transaction (single requester) or a contended pair, called at a
    // negedge while the selected instance is idle. The expected schedule is
    // derived from the window length: access cycles 1..A, done at A+1, and
    // for a pair an idle cycle, then access A+3..2A+2, done at 2A+3.
    task automatic run(input bit en0, input bit en1, input bit drop,
                       input bit rw0_i, input logic [5:0] a0_i, input logic [3:0] di0_i,
                       input bit rw1_i, input logic [5:0] a1_i, input logic [3:0] di1_i);
        int         s, acc, kend;
        bit         pair, first, own, ex_e, ex_done;
        bit         crw [2];
        logic [5:0] ca  [2];
        logic [3:0] cdi [2];
        s   = sel ? 1 : 0;
        acc = sel ? 3 : 1;
        crw[0] = rw0_i; ca[0] = a0_i; cdi[0] = di0_i;
        crw[1] = rw1_i; ca[1] = a1_i; cdi[1] = di1_i;
        pair  = en0 && en1;
        first = pair ? !last_ref[s] : en1;
        kend  = pair ? 2 * acc + 3 : acc + 1;
        r0_req = en0; r0_rw = rw0_i; r0_a = a0_i; r0_di = di0_i;
        r1_req = en1; r1_rw = rw1_i; r1_a = a1_i; r1_di = di1_i;
        for (int k = 1; k <= kend; k++) begin
            @(posedge clk);
            @(negedge clk);
            own     = (k <= acc + 1) ? first : !first;
            ex_e    = (k <= acc) || (k >= acc + 3 && k <= 2 * acc + 2);
            ex_done = (k == acc + 1) || (k == 2 * acc + 3);
            chk("mem_e", o_e, ex_e);
            chk("gnt", {o_g1, o_g0}, (ex_e || ex_done) ? (own ? 2'b10 : 2'b01) : 2'b00);
            chk("done", {o_d1, o_d0}, ex_done ? (own ? 2'b10 : 2'b01) : 2'b00);
            if (ex_e) begin
                chk("mem_rw", o_rw, crw[own]);
                chk("mem_a",  o_a,  ca[own]);
                chk("mem_di", o_di, cdi[own]);
                if (k == 1 || k == acc + 3) scramble(own);
            end else begin
                chk("mem_rw_park", o_rw, 1'b1);
            end
            if (drop && k == (acc + 1) / 2) set_req(own, 1'b0);
            if (ex_done) begin
                apply(s, own, crw[own], ca[own], cdi[own]);
                chk("rd0", o_rd0, ref_rd[s][0]);
                chk("rd1", o_rd1, ref_rd[s][1]);
                set_req(own, 1'b0);
                last_ref[s] = own;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_quiet", {o_d1, o_d0}, 2'b00);
    endtask

    always @(negedge clk) begin
        if (rst_n) chk("gnt_excl", {6'd0, g0 & g1}, 8'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=no summary expected=summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        // write then read back on the single-cycle instance
        sel = 1'b0;
        run(1, 0, 0, 1'b0, 6'h2A, 4'hF, 1'b0, 6'h00, 4'h0);
        run(1, 0, 0, 1'b1, 6'h2A, 4'h0, 1'b0, 6'h00, 4'h0);

        // contention right after reset on the three-cycle instance
        sel = 1'b1;
        run(1, 1, 0, 1'b0, 6'h10, 4'h3, 1'b0, 6'h11, 4'h9);
        run(1, 1, 0, 1'b1, 6'h11, 4'h0, 1'b1, 6'h10, 4'h0);

        // cross-requester visibility
        sel = 1'b0;
        run(0, 1, 0, 1'b0, 6'h00, 4'h0, 1'b0, 6'h01, 4'h5);
        run(1, 0, 0, 1'b1, 6'h01, 4'h0, 1'b0, 6'h00, 4'h0);
        run(1, 0, 0, 1'b1, 6'h2A, 4'h0, 1'b0, 6'h00, 4'h0);

        // long window write, then one with req dropped mid-access
        sel = 1'b1;
        run(0, 1, 0, 1'b0, 6'h00, 4'h0, 1'b0, 6'h3F, 4'h6);
        run(0, 1, 1, 1'b0, 6'h00, 4'h0, 1'b0, 6'h20, 4'hB);
        run(0, 1, 0, 1'b1, 6'h00, 4'h0, 1'b1, 6'h20, 4'h0);

        // randomized traffic on both instances
        for (int n = 0; n < 40; n++) begin
            int         mode;
            logic [5:0] ra0, ra1;
            sel  = 1'($urandom);
            mode = int'($urandom_range(0, 2));
            ra0  = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 15));
            ra1  = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(0, 15));
            run(mode != 1, mode != 0, 1'($urandom_range(0, 3) == 0),
                1'($urandom), ra0, 4'($urandom),
                1'($urandom), ra1, 4'($urandom));
        end

`ifdef MEM_ARB_LOCK_EN
        begin : lock_blk
            int         nseen;
            int         r0cnt;
            bit         who;
            logic [5:0] la [3];
            la[0] = 6'h2A; la[1] = 6'h01; la[2] = 6'h3F;
            sel = 1'b0;
            run(0, 1, 0, 1'b0, 6'h00, 4'h0, 1'b0, 6'h05, 4'h7);
            nseen = 0;
            r0cnt = 0;
            r0_lock = 1'b1;
            r1_req = 1'b1; r1_rw = 1'b0; r1_a = 6'h05; r1_di = 4'hA;
            r0_req = 1'b1; r0_rw = 1'b1; r0_a = la[0]; r0_di = 4'h0;
            for (int c = 0; c < 40 && nseen < 4; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (o_d0 || o_d1) begin
                    who = o_d1;
                    chk("lock_order", who, (nseen < 3) ? 1'b0 : 1'b1);
                    if (who) apply(0, 1'b1, r1_rw, r1_a, r1_di);
                    else     apply(0, 1'b0, r0_rw, r0_a, r0_di);
                    chk("lock_rd0", o_rd0, ref_rd[0][0]);
                    chk("lock_rd1", o_rd1, ref_rd[0][1]);
                    if (who) begin
                        r1_req = 1'b0;
                    end else begin
                        r0cnt++;
                        if (r0cnt == 2) r0_lock = 1'b0;
                        if (r0cnt < 3) r0_a = la[r0cnt];
                        else           r0_req = 1'b0;
                    end
                    nseen++;
                end
            end
            chk("lock_count", 8'(nseen), 8'd4);
            r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0;
            last_ref[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
`endif

        // reset in the middle of an access window
        sel = 1'b1;
        r1_req = 1'b1; r1_rw = 1'b0; r1_a = 6'h3F; r1_di = 4'hC;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_mem_e", o_e, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        r1_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_done", {d1, d0}, 4'h0);
        end

        // first tie after reset goes to r0 on both instances
        sel = 1'b1;
        run(1, 1, 0, 1'b0, 6'h07, 4'hD, 1'b0, 6'h08, 4'h2);
        run(1, 1, 0, 1'b1, 6'h08, 4'h0, 1'b1, 6'h07, 4'h0);
        sel = 1'b0;
        run(1, 1, 0, 1'b0, 6'h3F, 4'h9, 1'b1, 6'h3F, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
